// File: rtl/controlador_autenticacao.sv
// Sequential front-end for the authentication comparator: code/password capture, priority-resolved grant,
// failure counting and timed lockout. Define TIMEOUT_EN to add a password-entry timeout.
module controlador_autenticacao #(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TEMPO_ACESSO   = 8,
    parameter int TEMPO_NEGADO   = 4,
    parameter int TEMPO_BLOQUEIO = 16,
    parameter int TEMPO_ESPERA   = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] CODIGO,
    input  logic       CONFIRMA,
    input  logic       SAIR,
    input  logic [2:0] AUT,
    output logic [2:0] USUARIO,
    output logic [2:0] SENHA,
    output logic [2:0] NIVEL,
    output logic       ACESSO,
    output logic       NEGADO,
    output logic       BLOQUEADO,
    output logic [1:0] TENTATIVAS,
    output logic [2:0] ESTADO
);

    typedef enum logic [2:0] {
        ESPERA_USUARIO = 3'd0,
        ESPERA_SENHA   = 3'd1,
        COMPARA        = 3'd2,
        AVALIA         = 3'd3,
        LIBERADO       = 3'd4,
        ST_NEGADO      = 3'd5,
        BLOQUEIO       = 3'd6
    } state_t;

    localparam logic [7:0] LOAD_ACESSO   = 8'(TEMPO_ACESSO - 1);
    localparam logic [7:0] LOAD_NEGADO   = 8'(TEMPO_NEGADO - 1);
    localparam logic [7:0] LOAD_BLOQUEIO = 8'(TEMPO_BLOQUEIO - 1);
    localparam logic [2:0] MAX_T         = 3'(MAX_TENTATIVAS);

    // Elaboration-time range checks on the configuration.
    if (MAX_TENTATIVAS < 1 || MAX_TENTATIVAS > 3) begin : g_bad_max
        $error("MAX_TENTATIVAS out of range 1..3");
    end
    if (TEMPO_ACESSO < 1 || TEMPO_ACESSO > 256 || TEMPO_NEGADO < 1 || TEMPO_NEGADO > 256 ||
        TEMPO_BLOQUEIO < 1 || TEMPO_BLOQUEIO > 256 || TEMPO_ESPERA < 1 || TEMPO_ESPERA > 256) begin : g_bad_tempo
        $error("TEMPO_* out of range 1..256");
    end

`ifdef TIMEOUT_EN
    localparam logic [7:0] LOAD_ESPERA = 8'(TEMPO_ESPERA - 1);
`endif

    state_t     state, next_state;
    logic [7:0] timer, next_timer;
    logic [2:0] next_usuario, next_senha, next_nivel;
    logic [1:0] next_tent;
    logic       confirma_q, sair_q;
    logic       confirma_edge, sair_edge;

    assign confirma_edge = CONFIRMA & ~confirma_q;
    assign sair_edge     = SAIR & ~sair_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ESPERA_USUARIO;
            timer      <= '0;
            USUARIO    <= '0;
            SENHA      <= '0;
            NIVEL      <= '0;
            TENTATIVAS <= '0;
            // Held buttons across reset release must not register as a press.
            confirma_q <= 1'b1;
            sair_q     <= 1'b1;
        end else begin
            state      <= next_state;
            timer      <= next_timer;
            USUARIO    <= next_usuario;
            SENHA      <= next_senha;
            NIVEL      <= next_nivel;
            TENTATIVAS <= next_tent;
            confirma_q <= CONFIRMA;
            sair_q     <= SAIR;
        end
    end

    always_comb begin
        next_state   = state;
        next_usuario = USUARIO;
        next_senha   = SENHA;
        next_nivel   = NIVEL;
        next_tent    = TENTATIVAS;
        next_timer   = (timer != '0) ? timer - 8'd1 : '0;

        case (state)
            ESPERA_USUARIO: begin
                if (confirma_edge) begin
                    next_usuario = CODIGO;
                    next_state   = ESPERA_SENHA;
                end
            end
            ESPERA_SENHA: begin
                if (confirma_edge) begin
                    next_senha = CODIGO;
                    next_state = COMPARA;
                end
`ifdef TIMEOUT_EN
                else if (timer == '0) begin
                    next_usuario = '0;
                    next_state   = ESPERA_USUARIO;
                end
`endif
            end
            COMPARA: next_state = AVALIA;
            AVALIA: begin
                if (AUT != '0) begin
                    next_nivel = AUT[2] ? 3'b100 : (AUT[1] ? 3'b010 : 3'b001);
                    next_tent  = '0;
                    next_state = LIBERADO;
                end else if ({1'b0, TENTATIVAS} + 3'd1 < MAX_T) begin
                    next_tent  = TENTATIVAS + 2'd1;
                    next_state = ST_NEGADO;
                end else begin
                    next_tent  = 2'(MAX_TENTATIVAS);
                    next_state = BLOQUEIO;
                end
            end
            LIBERADO: begin
                if (sair_edge || timer == '0) begin
                    next_usuario = '0;
                    next_senha   = '0;
                    next_nivel   = '0;
                    next_state   = ESPERA_USUARIO;
                end
            end
            ST_NEGADO: begin
                if (timer == '0) begin
                    next_usuario = '0;
                    next_senha   = '0;
                    next_state   = ESPERA_USUARIO;
                end
            end
            BLOQUEIO: begin
                if (timer == '0) begin
                    next_tent    = '0;
                    next_usuario = '0;
                    next_senha   = '0;
                    next_state   = ESPERA_USUARIO;
                end
            end
            default: next_state = ESPERA_USUARIO;
        endcase

        // Timer is loaded with T-1 on entry so the state lasts exactly T cycles.
        if (next_state != state) begin
            case (next_state)
                LIBERADO:     next_timer = LOAD_ACESSO;
                ST_NEGADO:    next_timer = LOAD_NEGADO;
                BLOQUEIO:     next_timer = LOAD_BLOQUEIO;
`ifdef TIMEOUT_EN
                ESPERA_SENHA: next_timer = LOAD_ESPERA;
`endif
                default:      next_timer = '0;
            endcase
        end
    end

    assign ACESSO    = (state == LIBERADO);
    assign NEGADO    = (state == ST_NEGADO);
    assign BLOQUEADO = (state == BLOQUEIO);
    assign ESTADO    = state;

endmodule

// File: tb/tb_controlador_autenticacao.sv
// Self-checking bench for controlador_autenticacao: vector table, hand-written corner sequences
// and randomized transactions checked against a transaction-level model of the access rules.
module tb_controlador_autenticacao;

    localparam int MAXT = 3;
    localparam int TA   = 8;
    localparam int TN   = 4;
    localparam int TBQ  = 16;
    localparam int TE   = 32;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] CODIGO, AUT;
    logic       CONFIRMA, SAIR;
    logic [2:0] USUARIO, SENHA, NIVEL, ESTADO;
    logic       ACESSO, NEGADO, BLOQUEADO;
    logic [1:0] TENTATIVAS;

    controlador_autenticacao #(
        .MAX_TENTATIVAS(MAXT),
        .TEMPO_ACESSO(TA),
        .TEMPO_NEGADO(TN),
        .TEMPO_BLOQUEIO(TBQ),
        .TEMPO_ESPERA(TE)
    ) dut (
        .CLK(CLK), .RST(RST), .CODIGO(CODIGO), .CONFIRMA(CONFIRMA), .SAIR(SAIR), .AUT(AUT),
        .USUARIO(USUARIO), .SENHA(SENHA), .NIVEL(NIVEL), .ACESSO(ACESSO), .NEGADO(NEGADO),
        .BLOQUEADO(BLOQUEADO), .TENTATIVAS(TENTATIVAS), .ESTADO(ESTADO)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int m_tent = 0;

    // outcome kinds: 0 = granted, 1 = denied, 2 = locked out
    typedef struct {
        logic [2:0] u;
        logic [2:0] p;
        logic [2:0] a;
        logic [2:0] nivel;
        int         kind;
        int         tent;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2:0] top_level(input logic [2:0] a);
        logic [2:0] r = '0;
        for (int unsigned i = 0; i < 3; i++)
            if (a[i]) r = 3'(1 << i);
        return r;
    endfunction

    // One complete login attempt, checked cycle by cycle through the result state.
    task automatic run_txn(input logic [2:0] u, input logic [2:0] p, input logic [2:0] a,
                           input int hold_u, input int sair_k, input int kind,
                           input logic [2:0] exp_nivel, input int exp_tent, input string tag);
        int dur;
        CONFIRMA = 1'b0; SAIR = 1'b0;
        step();
        chk({tag, " idle ESTADO"}, ESTADO, 0);
        CODIGO = u; CONFIRMA = 1'b1;
        repeat (hold_u) step();
        CONFIRMA = 1'b0; CODIGO = 3'($urandom);
        step();
        chk({tag, " senha ESTADO"}, ESTADO, 1);
        chk({tag, " USUARIO"}, USUARIO, u);
        CODIGO = p; AUT = a; CONFIRMA = 1'b1;
        step();
        chk({tag, " compara ESTADO"}, ESTADO, 2);
        chk({tag, " SENHA"}, SENHA, p);
        CONFIRMA = 1'b0;
        step();
        chk({tag, " avalia ESTADO"}, ESTADO, 3);
        step();
        if (kind == 0) dur = (sair_k + 1 < TA) ? sair_k + 1 : TA;
        else if (kind == 1) dur = TN;
        else dur = TBQ;
        for (int k = 0; k < dur; k++) begin
            chk({tag, " res ESTADO"}, ESTADO, 4 + kind);
            chk({tag, " ACESSO"}, ACESSO, kind == 0);
            chk({tag, " NEGADO"}, NEGADO, kind == 1);
            chk({tag, " BLOQUEADO"}, BLOQUEADO, kind == 2);
            chk({tag, " NIVEL"}, NIVEL, (kind == 0) ? exp_nivel : 3'b000);
            chk({tag, " TENTATIVAS"}, TENTATIVAS, exp_tent);
            chk({tag, " res USUARIO"}, USUARIO, u);
            if (kind == 2) CONFIRMA = (k % 3 == 1);
            if (kind == 0 && k == sair_k) SAIR = 1'b1;
            step();
        end
        CONFIRMA = 1'b0; SAIR = 1'b0;
        chk({tag, " exit ESTADO"}, ESTADO, 0);
        chk({tag, " exit USUARIO"}, USUARIO, 0);
        chk({tag, " exit SENHA"}, SENHA, 0);
        chk({tag, " exit NIVEL"}, NIVEL, 0);
        chk({tag, " exit TENTATIVAS"}, TENTATIVAS, (kind == 2) ? 0 : exp_tent);
    endtask

    // Model of the access rules at transaction level: returns kind, level and count during result.
    task automatic model_attempt(input logic [2:0] a, output int kind, output logic [2:0] nv, output int tent);
        nv = '0;
        if (a != 0) begin
            kind = 0; nv = top_level(a); m_tent = 0; tent = 0;
        end else if (m_tent + 1 < MAXT) begin
            kind = 1; m_tent++; tent = m_tent;
        end else begin
            kind = 2; tent = MAXT; m_tent = 0;
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1; #1; RST = 1'b0;
        m_tent = 0;
    endtask

    initial begin
        int kind, tent, sk;
        logic [2:0] u, p, a, nv;

        tbl = '{
            '{3'b011, 3'b100, 3'b010, 3'b010, 0, 0},
            '{3'b001, 3'b010, 3'b101, 3'b100, 0, 0},
            '{3'b111, 3'b111, 3'b001, 3'b001, 0, 0},
            '{3'b000, 3'b000, 3'b000, 3'b000, 1, 1},
            '{3'b010, 3'b011, 3'b100, 3'b100, 0, 0},
            '{3'b000, 3'b001, 3'b000, 3'b000, 1, 1},
            '{3'b000, 3'b001, 3'b000, 3'b000, 1, 2},
            '{3'b000, 3'b001, 3'b000, 3'b000, 2, 3},
            '{3'b110, 3'b101, 3'b011, 3'b010, 0, 0},
            '{3'b101, 3'b110, 3'b111, 3'b100, 0, 0}
        };

        RST = 1'b1; CODIGO = '0; AUT = '0; CONFIRMA = 1'b0; SAIR = 1'b0;
        #12;
        chk("rst ESTADO", ESTADO, 0);
        chk("rst USUARIO", USUARIO, 0);
        chk("rst SENHA", SENHA, 0);
        chk("rst NIVEL", NIVEL, 0);
        chk("rst TENTATIVAS", TENTATIVAS, 0);
        chk("rst flags", {ACESSO, NEGADO, BLOQUEADO}, 0);
        @(posedge CLK); #1; RST = 1'b0;

        foreach (tbl[i])
            run_txn(tbl[i].u, tbl[i].p, tbl[i].a, 1, 1000, tbl[i].kind, tbl[i].nivel, tbl[i].tent, "tbl");

        // Logout on the third LIBERADO cycle.
        run_txn(3'b001, 3'b001, 3'b110, 1, 2, 0, 3'b100, 0, "sair");

        // Long CONFIRMA hold captures only the user code.
        CONFIRMA = 1'b0; step();
        CODIGO = 3'b101; CONFIRMA = 1'b1;
        step();
        CODIGO = 3'b010;
        repeat (9) step();
        chk("hold ESTADO", ESTADO, 1);
        chk("hold USUARIO", USUARIO, 3'b101);
        chk("hold SENHA", SENHA, 0);
        CONFIRMA = 1'b0;
        pulse_reset();
        chk("hold rst ESTADO", ESTADO, 0);

        for (int n = 0; n < 30; n++) begin
            u = 3'($urandom); p = 3'($urandom);
            a = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(1, 7));
            sk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, TA - 1) : 1000;
            model_attempt(a, kind, nv, tent);
            run_txn(u, p, a, $urandom_range(1, 4), sk, kind, nv, tent, "rnd");
        end

        // Password entry with no confirmation.
        pulse_reset();
        model_attempt(3'b000, kind, nv, tent);
        run_txn(3'b010, 3'b010, 3'b000, 1, 1000, kind, nv, tent, "pre_to");
        CONFIRMA = 1'b0; step();
        CODIGO = 3'b011; CONFIRMA = 1'b1; step(); CONFIRMA = 1'b0;
`ifdef TIMEOUT_EN
        for (int k = 0; k < TE; k++) begin
            chk("to wait ESTADO", ESTADO, 1);
            step();
        end
        chk("to ESTADO", ESTADO, 0);
        chk("to USUARIO", USUARIO, 0);
        chk("to TENTATIVAS", TENTATIVAS, m_tent);
`else
        repeat (TE + 8) step();
        chk("no-to ESTADO", ESTADO, 1);
        chk("no-to USUARIO", USUARIO, 3'b011);
        chk("no-to TENTATIVAS", TENTATIVAS, m_tent);
`endif
        pulse_reset();

        // Asynchronous reset in the middle of LIBERADO, buttons held through release.
        CONFIRMA = 1'b0; step();
        CODIGO = 3'b110; CONFIRMA = 1'b1; step(); CONFIRMA = 1'b0; step();
        CODIGO = 3'b001; AUT = 3'b100; CONFIRMA = 1'b1; step(); CONFIRMA = 1'b0;
        repeat (4) step();
        chk("mid ACESSO", ACESSO, 1);
        CONFIRMA = 1'b1; SAIR = 1'b1;
        RST = 1'b1; #1;
        chk("async ESTADO", ESTADO, 0);
        chk("async ACESSO", ACESSO, 0);
        chk("async NIVEL", NIVEL, 0);
        chk("async USUARIO", USUARIO, 0);
        chk("async SENHA", SENHA, 0);
        step(); RST = 1'b0;
        repeat (3) step();
        chk("held-through-reset ESTADO", ESTADO, 0);
        chk("held-through-reset USUARIO", USUARIO, 0);
        CONFIRMA = 1'b0; SAIR = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
